// File: rtl/note_seq_pkg.sv
// Shared types and note-code constants for the note sequencer.
// The state encoding doubles as the externally visible mode value.
package note_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        PLAY   = 2'b10
    } seq_state_t;

    localparam logic [3:0] NOTE_NONE    = 4'd0;
    localparam logic [3:0] NOTE_MAX     = 4'd13;
    localparam logic [3:0] NOTE_REST    = 4'd14;
    localparam logic [3:0] NOTE_INVALID = 4'd15;

    // Pitches and rests are recorded; "no key" and invalid codes are not.
    function automatic logic key_storable(input logic [3:0] key);
        return ((key != NOTE_NONE) && (key <= NOTE_MAX)) || (key == NOTE_REST);
    endfunction

    // A rest occupies a slot but plays as silence.
    function automatic logic [3:0] key_to_slot(input logic [3:0] key);
        return (key == NOTE_REST) ? NOTE_NONE : key;
    endfunction

endpackage

// File: rtl/note_timer.sv
// Tempo timer: counts enabled cycles and pulses expire on the last cycle
// of each TEMPO_CYCLES-long period, wrapping back to zero.
module note_timer #(
    parameter int TEMPO_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = (TEMPO_CYCLES > 1) ? $clog2(TEMPO_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TEMPO_CYCLES - 1);

    logic [TW-1:0] tempo_reg;
    logic [TW-1:0] tempo_next;

    assign expire = enable && !clear && (tempo_reg == LAST);

    always_comb begin
        tempo_next = tempo_reg;
        if (clear) begin
            tempo_next = '0;
        end else if (enable) begin
            tempo_next = expire ? '0 : tempo_reg + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tempo_reg <= '0;
        end else begin
            tempo_reg <= tempo_next;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Keypad note recorder with fixed-tempo playback toward the frequency divider.
// keycode passes to the divider untouched; this block only drives sound_series.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int TEMPO_CYCLES = 2_500_000
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic [3:0]               keycode,
    input  logic                     record_btn,
    input  logic                     play_btn,
    output logic [3:0]               sound_series,
    output logic [1:0]               mode,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    seq_state_t    state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [3:0]    sound_reg, sound_next;
    logic          full_reg, full_next;
    logic [3:0]    prev_key_reg;

    logic [3:0]    note_buf [DEPTH];
    logic          wr_en;
    logic [3:0]    wr_data;
    logic          capture;
    logic          last_slot;
    logic [IW-1:0] idx_inc;
    logic [CW-1:0] count_m1;
    logic          timer_clear;
    logic          timer_expire;

    assign sound_series = sound_reg;
    assign mode         = state_reg;
    assign count        = count_reg;
    assign full         = full_reg;

    // Press edge only, so a held key yields a single slot.
    assign capture   = (prev_key_reg == NOTE_NONE) && key_storable(keycode) && !full_reg;
    assign idx_inc   = idx_reg + IW'(1);
    assign count_m1  = count_reg - CW'(1);
    assign last_slot = ({1'b0, idx_reg} == count_m1);

    // Timer idles at zero outside PLAY so a new playback starts a full period.
    assign timer_clear = (state_reg != PLAY) || play_btn;

    note_timer #(
        .TEMPO_CYCLES(TEMPO_CYCLES)
    ) u_timer (
        .clk    (clk),
        .nRst   (nRst),
        .clear  (timer_clear),
        .enable (state_reg == PLAY),
        .expire (timer_expire)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        idx_next   = idx_reg;
        sound_next = NOTE_NONE;
        wr_en      = 1'b0;
        wr_data    = key_to_slot(keycode);

        case (state_reg)
            IDLE: begin
                if (record_btn) begin
                    state_next = RECORD;
                    count_next = '0;
                end else if (play_btn && (count_reg != '0)) begin
                    state_next = PLAY;
                    idx_next   = '0;
                    sound_next = note_buf[0];
                end
            end

            RECORD: begin
                if (capture) begin
                    wr_en      = 1'b1;
                    count_next = count_reg + CW'(1);
                end
                if (record_btn) begin
                    state_next = IDLE;
                end
            end

            PLAY: begin
                sound_next = sound_reg;
                if (play_btn) begin
                    state_next = IDLE;
                    sound_next = NOTE_NONE;
                end else if (timer_expire) begin
                    if (last_slot) begin
                        state_next = IDLE;
                        sound_next = NOTE_NONE;
                    end else begin
                        idx_next   = idx_inc;
                        sound_next = note_buf[idx_inc];
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        full_next = (count_next == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            idx_reg      <= '0;
            sound_reg    <= NOTE_NONE;
            full_reg     <= 1'b0;
            prev_key_reg <= NOTE_NONE;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            idx_reg      <= idx_next;
            sound_reg    <= sound_next;
            full_reg     <= full_next;
            prev_key_reg <= keycode;
        end
    end

    // Buffer is deliberately unreset; count alone defines its valid contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            note_buf[count_reg[IW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer with DEPTH=4, TEMPO_CYCLES=4.
module tb_note_sequencer;

    logic       clk;
    logic       nRst;
    logic [3:0] keycode;
    logic       record_btn;
    logic       play_btn;
    logic [3:0] sound_series;
    logic [1:0] mode;
    logic [2:0] count;
    logic       full;

    int checks;
    int failures;

    note_sequencer #(
        .DEPTH        (4),
        .TEMPO_CYCLES (4)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .keycode      (keycode),
        .record_btn   (record_btn),
        .play_btn     (play_btn),
        .sound_series (sound_series),
        .mode         (mode),
        .count        (count),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] key);
        keycode = key;
        tick();
        keycode = 4'd0;
        tick();
    endtask

    task automatic test_reset();
        nRst = 1'b0; keycode = 4'd0; record_btn = 1'b0; play_btn = 1'b0;
        #2;
        checks++;
        if (sound_series !== 4'd0 || mode !== 2'b00 || count !== 3'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: sound=%0d mode=%b count=%0d full=%b, required 0 00 0 0",
                     sound_series, mode, count, full);
        end
        tick(); tick();
        #2 nRst = 1'b1;
        tick();
        $display("test_reset: sound=%0d mode=%b count=%0d", sound_series, mode, count);
    endtask

    task automatic test_record();
        record_btn = 1'b1; tick(); record_btn = 1'b0;
        checks++;
        if (mode !== 2'b01 || count !== 3'd0) begin
            failures++;
            $display("FAIL record_enter: mode=%b count=%0d, required 01 0", mode, count);
        end
        keycode = 4'd5;
        repeat (10) tick();
        checks++;
        if (count !== 3'd1) begin
            failures++;
            $display("FAIL record_held: count=%0d, required 1", count);
        end
        keycode = 4'd0; tick();
        press(4'd15);
        checks++;
        if (count !== 3'd1) begin
            failures++;
            $display("FAIL record_invalid: count=%0d, required 1", count);
        end
        press(4'd14);
        press(4'd13);
        checks++;
        if (sound_series !== 4'd0) begin
            failures++;
            $display("FAIL record_silent: sound=%0d, required 0", sound_series);
        end
        record_btn = 1'b1; tick(); record_btn = 1'b0;
        checks++;
        if (count !== 3'd3 || mode !== 2'b00 || full !== 1'b0) begin
            failures++;
            $display("FAIL record_exit: count=%0d mode=%b full=%b, required 3 00 0", count, mode, full);
        end
        $display("test_record: count=%0d mode=%b", count, mode);
    endtask

    task automatic test_playback();
        logic [3:0] vals [3];
        int bad;
        vals[0] = 4'd5; vals[1] = 4'd0; vals[2] = 4'd13;
        bad = 0;
        play_btn = 1'b1; tick(); play_btn = 1'b0;
        checks++;
        if (mode !== 2'b10) begin
            failures++;
            $display("FAIL play_mode: mode=%b, required 10", mode);
        end
        for (int i = 1; i <= 12; i++) begin
            checks++;
            if (sound_series !== vals[(i - 1) / 4]) begin
                failures++;
                bad++;
                $display("FAIL play_seq cycle N+%0d: sound=%0d, required %0d", i, sound_series, vals[(i - 1) / 4]);
            end
            tick();
        end
        checks++;
        if (sound_series !== 4'd0 || mode !== 2'b00) begin
            failures++;
            $display("FAIL play_end: sound=%0d mode=%b, required 0 00", sound_series, mode);
        end
        $display("test_playback: 12 cycles checked, %0d wrong", bad);
    endtask

    task automatic test_reset_mid_play();
        play_btn = 1'b1; tick(); play_btn = 1'b0;
        tick(); tick();
        #2 nRst = 1'b0;
        #1;
        checks++;
        if (sound_series !== 4'd0 || mode !== 2'b00 || count !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_play: sound=%0d mode=%b count=%0d, required 0 00 0",
                     sound_series, mode, count);
        end
        #2 nRst = 1'b1;
        tick();
        play_btn = 1'b1; tick(); play_btn = 1'b0;
        checks++;
        if (mode !== 2'b00 || sound_series !== 4'd0) begin
            failures++;
            $display("FAIL play_empty: mode=%b sound=%0d, required 00 0", mode, sound_series);
        end
        $display("test_reset_mid_play: mode=%b count=%0d", mode, count);
    endtask

    task automatic test_overflow();
        logic [3:0] keys [6];
        logic [3:0] vals [4];
        keys[0] = 4'd1; keys[1] = 4'd2; keys[2] = 4'd3; keys[3] = 4'd4; keys[4] = 4'd6; keys[5] = 4'd7;
        vals[0] = 4'd1; vals[1] = 4'd2; vals[2] = 4'd3; vals[3] = 4'd4;
        record_btn = 1'b1; tick(); record_btn = 1'b0;
        for (int k = 0; k < 6; k++) press(keys[k]);
        checks++;
        if (count !== 3'd4 || full !== 1'b1) begin
            failures++;
            $display("FAIL overflow_count: count=%0d full=%b, required 4 1", count, full);
        end
        record_btn = 1'b1; tick(); record_btn = 1'b0;
        play_btn = 1'b1; tick(); play_btn = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (sound_series !== vals[(i - 1) / 4] || mode !== 2'b10) begin
                failures++;
                $display("FAIL overflow_play cycle N+%0d: sound=%0d mode=%b, required %0d 10",
                         i, sound_series, mode, vals[(i - 1) / 4]);
            end
            tick();
        end
        checks++;
        if (sound_series !== 4'd0 || mode !== 2'b00) begin
            failures++;
            $display("FAIL overflow_end: sound=%0d mode=%b, required 0 00", sound_series, mode);
        end
        $display("test_overflow: count=%0d full=%b", count, full);
    endtask

    task automatic test_stop_simul();
        play_btn = 1'b1; tick(); play_btn = 1'b0;
        repeat (5) tick();
        checks++;
        if (sound_series !== 4'd2) begin
            failures++;
            $display("FAIL stop_before: sound=%0d, required 2", sound_series);
        end
        play_btn = 1'b1; tick(); play_btn = 1'b0;
        checks++;
        if (sound_series !== 4'd0 || mode !== 2'b00) begin
            failures++;
            $display("FAIL stop_play: sound=%0d mode=%b, required 0 00", sound_series, mode);
        end
        record_btn = 1'b1; play_btn = 1'b1; tick(); record_btn = 1'b0; play_btn = 1'b0;
        checks++;
        if (mode !== 2'b01 || count !== 3'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL simul_btn: mode=%b count=%0d full=%b, required 01 0 0", mode, count, full);
        end
        record_btn = 1'b1; tick(); record_btn = 1'b0;
        $display("test_stop_simul: mode=%b count=%0d", mode, count);
    endtask

    task automatic test_held_key();
        keycode = 4'd9;
        tick(); tick();
        record_btn = 1'b1; tick(); record_btn = 1'b0;
        repeat (5) tick();
        checks++;
        if (count !== 3'd0 || mode !== 2'b01) begin
            failures++;
            $display("FAIL held_entry: count=%0d mode=%b, required 0 01", count, mode);
        end
        keycode = 4'd0; tick();
        press(4'd9);
        checks++;
        if (count !== 3'd1) begin
            failures++;
            $display("FAIL held_repress: count=%0d, required 1", count);
        end
        record_btn = 1'b1; tick(); record_btn = 1'b0;
        play_btn = 1'b1; tick(); play_btn = 1'b0;
        checks++;
        if (sound_series !== 4'd9) begin
            failures++;
            $display("FAIL held_play: sound=%0d, required 9", sound_series);
        end
        repeat (4) tick();
        checks++;
        if (sound_series !== 4'd0 || mode !== 2'b00) begin
            failures++;
            $display("FAIL held_end: sound=%0d mode=%b, required 0 00", sound_series, mode);
        end
        $display("test_held_key: count=%0d", count);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_record();
        test_playback();
        test_reset_mid_play();
        test_overflow();
        test_stop_simul();
        test_held_key();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
